// File: rtl/ppu_vram_loader.sv
`timescale 1ns/1ps
// Byte-stream writer for the PPU tile memories (char, chardata, charpal port A).
// Optional PPU_LOADER_VBLANK_GATE_EN: adds vblank input; data bytes accepted only while vblank is high.
module ppu_vram_loader #(
   parameter int CHAR_AW     = 12,
   parameter int CHARDATA_AW = 12,
   parameter int PAL_AW      = 10,
   parameter int PAL_DW      = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
`ifdef PPU_LOADER_VBLANK_GATE_EN
   input  logic                   vblank,
`endif
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   char_we,
   output logic [CHAR_AW-1:0]     char_addr,
   output logic [7:0]             char_din,
   output logic                   cdat_we,
   output logic [CHARDATA_AW-1:0] cdat_addr,
   output logic [7:0]             cdat_din,
   output logic                   pal_we,
   output logic [PAL_AW-1:0]      pal_addr,
   output logic [PAL_DW-1:0]      pal_din,
   output logic                   busy,
   output logic                   pkt_done,
   output logic                   pkt_err
);

   localparam logic [1:0] T_CHAR = 2'b00;
   localparam logic [1:0] T_CDAT = 2'b01;
   localparam logic [1:0] T_PAL  = 2'b10;

   typedef enum logic [2:0] {
      S_CMD, S_ADLO, S_LEN, S_DATA, S_PHI, S_PLO, S_DROP
   } state_t;

   state_t                 state_reg, state_next;
   logic [1:0]             tgt_reg, tgt_next;
   logic [11:0]            addr_reg, addr_next;
   logic [8:0]             len_reg, len_next;
   logic [8:0]             cnt_reg, cnt_next;
   logic [7:0]             hi_reg, hi_next;
   logic                   char_we_reg, char_we_next;
   logic [CHAR_AW-1:0]     char_addr_reg, char_addr_next;
   logic [7:0]             char_din_reg, char_din_next;
   logic                   cdat_we_reg, cdat_we_next;
   logic [CHARDATA_AW-1:0] cdat_addr_reg, cdat_addr_next;
   logic [7:0]             cdat_din_reg, cdat_din_next;
   logic                   pal_we_reg, pal_we_next;
   logic [PAL_AW-1:0]      pal_addr_reg, pal_addr_next;
   logic [PAL_DW-1:0]      pal_din_reg, pal_din_next;
   logic                   pkt_done_reg, pkt_done_next;
   logic                   pkt_err_reg, pkt_err_next;

   logic                   ready_int;
   logic                   accept;
   logic [8:0]             cnt_inc;
   logic                   last_word;
   logic [11:0]            addr_inc;

`ifdef PPU_LOADER_VBLANK_GATE_EN
   // Header bytes always pass; only memory-touching states wait for vertical blank.
   assign ready_int = (state_reg == S_DATA || state_reg == S_PHI || state_reg == S_PLO) ? vblank : 1'b1;
`else
   assign ready_int = 1'b1;
`endif

   assign accept    = in_valid & ready_int;
   assign cnt_inc   = cnt_reg + 9'd1;
   assign last_word = (cnt_inc == len_reg);
   assign addr_inc  = addr_reg + 12'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_CMD;
         tgt_reg       <= 2'b00;
         addr_reg      <= 12'd0;
         len_reg       <= 9'd0;
         cnt_reg       <= 9'd0;
         hi_reg        <= 8'd0;
         char_we_reg   <= 1'b0;
         char_addr_reg <= '0;
         char_din_reg  <= 8'd0;
         cdat_we_reg   <= 1'b0;
         cdat_addr_reg <= '0;
         cdat_din_reg  <= 8'd0;
         pal_we_reg    <= 1'b0;
         pal_addr_reg  <= '0;
         pal_din_reg   <= '0;
         pkt_done_reg  <= 1'b0;
         pkt_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         tgt_reg       <= tgt_next;
         addr_reg      <= addr_next;
         len_reg       <= len_next;
         cnt_reg       <= cnt_next;
         hi_reg        <= hi_next;
         char_we_reg   <= char_we_next;
         char_addr_reg <= char_addr_next;
         char_din_reg  <= char_din_next;
         cdat_we_reg   <= cdat_we_next;
         cdat_addr_reg <= cdat_addr_next;
         cdat_din_reg  <= cdat_din_next;
         pal_we_reg    <= pal_we_next;
         pal_addr_reg  <= pal_addr_next;
         pal_din_reg   <= pal_din_next;
         pkt_done_reg  <= pkt_done_next;
         pkt_err_reg   <= pkt_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      tgt_next       = tgt_reg;
      addr_next      = addr_reg;
      len_next       = len_reg;
      cnt_next       = cnt_reg;
      hi_next        = hi_reg;
      char_we_next   = 1'b0;
      char_addr_next = char_addr_reg;
      char_din_next  = char_din_reg;
      cdat_we_next   = 1'b0;
      cdat_addr_next = cdat_addr_reg;
      cdat_din_next  = cdat_din_reg;
      pal_we_next    = 1'b0;
      pal_addr_next  = pal_addr_reg;
      pal_din_next   = pal_din_reg;
      pkt_done_next  = 1'b0;
      pkt_err_next   = 1'b0;

      case (state_reg)
         S_CMD: begin
            if (accept) begin
               tgt_next     = in_data[7:6];
               addr_next    = {in_data[3:0], 8'h00};
               pkt_err_next = (in_data[7:6] == 2'b11);
               state_next   = S_ADLO;
            end
         end
         S_ADLO: begin
            if (accept) begin
               addr_next  = {addr_reg[11:8], in_data};
               state_next = S_LEN;
            end
         end
         S_LEN: begin
            if (accept) begin
               len_next = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
               cnt_next = 9'd0;
               case (tgt_reg)
                  T_CHAR, T_CDAT: state_next = S_DATA;
                  T_PAL:          state_next = S_PHI;
                  default:        state_next = S_DROP;
               endcase
            end
         end
         S_DATA: begin
            if (accept) begin
               if (tgt_reg == T_CHAR) begin
                  char_we_next   = 1'b1;
                  char_addr_next = CHAR_AW'(addr_reg);
                  char_din_next  = in_data;
               end else begin
                  cdat_we_next   = 1'b1;
                  cdat_addr_next = CHARDATA_AW'(addr_reg);
                  cdat_din_next  = in_data;
               end
               addr_next = addr_inc;
               cnt_next  = cnt_inc;
               if (last_word) begin
                  state_next    = S_CMD;
                  pkt_done_next = 1'b1;
               end
            end
         end
         S_PHI: begin
            if (accept) begin
               hi_next    = in_data;
               state_next = S_PLO;
            end
         end
         S_PLO: begin
            if (accept) begin
               pal_we_next   = 1'b1;
               pal_addr_next = PAL_AW'(addr_reg);
               pal_din_next  = PAL_DW'({hi_reg, in_data});
               addr_next     = addr_inc;
               cnt_next      = cnt_inc;
               if (last_word) begin
                  state_next    = S_CMD;
                  pkt_done_next = 1'b1;
               end else begin
                  state_next = S_PHI;
               end
            end
         end
         S_DROP: begin
            if (accept) begin
               cnt_next = cnt_inc;
               if (last_word) begin
                  state_next    = S_CMD;
                  pkt_done_next = 1'b1;
               end
            end
         end
         default: state_next = S_CMD;
      endcase
   end

   assign in_ready  = ready_int;
   assign char_we   = char_we_reg;
   assign char_addr = char_addr_reg;
   assign char_din  = char_din_reg;
   assign cdat_we   = cdat_we_reg;
   assign cdat_addr = cdat_addr_reg;
   assign cdat_din  = cdat_din_reg;
   assign pal_we    = pal_we_reg;
   assign pal_addr  = pal_addr_reg;
   assign pal_din   = pal_din_reg;
   assign busy      = (state_reg != S_CMD);
   assign pkt_done  = pkt_done_reg;
   assign pkt_err   = pkt_err_reg;

endmodule
